// File: rtl/board_status_display_if.sv
`default_nettype none
// board_status_display_if: pin-side bundle between the board, the SoC and the status display.
interface board_status_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_KEYS   = 2
);
  logic [NUM_KEYS-1:0]     KEY_n;
  logic                    LOCKUP;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_KEYS-1:0]     key_level;
  logic [NUM_KEYS-1:0]     key_press;
  logic                    heartbeat;
  logic                    running;
  logic                    lockup_seen;
  logic [1:0]              mode;
  logic [7*NUM_DIGITS-1:0] hex_n;

  modport master (
    output KEY_n, LOCKUP, value,
    input  key_level, key_press, heartbeat, running, lockup_seen, mode, hex_n
  );

  modport slave (
    input  KEY_n, LOCKUP, value,
    output key_level, key_press, heartbeat, running, lockup_seen, mode, hex_n
  );
endinterface
`default_nettype wire

// File: rtl/board_status_display.sv
`default_nettype none
// board_status_display: heartbeat, key debounce, sticky lockup counter and N-digit 7-seg driver. Rev 1.0
module board_status_display #(
  parameter int NUM_DIGITS      = 4,
  parameter int HB_MSB          = 25,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_KEYS        = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  HRESETn,
  board_status_display_if.slave bus
);

  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]      BLANK   = 7'b1111111;

  localparam logic [1:0] MODE_STATUS  = 2'd0;
  localparam logic [1:0] MODE_HEX     = 2'd1;
  localparam logic [1:0] MODE_LOCKCNT = 2'd2;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b0000011;
      4'hC:    seg7 = 7'b1000110;
      4'hD:    seg7 = 7'b0100001;
      4'hE:    seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  logic [HB_MSB:0]         tick_q, tick_d;
  logic                    heartbeat_q, heartbeat_d;
  logic                    running_q;
  logic                    lockup_seen_q, lockup_seen_d;
  logic                    lock_prev_q;
  logic [7:0]              lock_cnt_q, lock_cnt_d;
  logic [1:0]              mode_q, mode_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_KEYS-1:0]     key_level_w, key_press_w;
  logic [NUM_KEYS:0]       kp_ext_w;

  // Two-flop synchroniser on the inverted key, then a stability counter that
  // flips the level on its last count so the edge-to-level latency is 2 + DEBOUNCE_CYCLES.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             meta_q, sync_q;
    logic             lvl_q, lvl_d;
    logic             press_q, press_d;

    always_comb begin
      cnt_d   = '0;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      if (sync_q != lvl_q) begin
        if (cnt_q == DB_LAST) begin
          lvl_d   = ~lvl_q;
          press_d = ~lvl_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
      if (!HRESETn) begin
        meta_q  <= 1'b0;
        sync_q  <= 1'b0;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
      end else begin
        meta_q  <= ~bus.KEY_n[k];
        sync_q  <= meta_q;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        press_q <= press_d;
      end
    end

    assign key_level_w[k] = lvl_q;
    assign key_press_w[k] = press_q;
  end

  // Zero-extended so the clear key reads as idle on single-key builds.
  assign kp_ext_w = {1'b0, key_press_w};

  always_comb begin
    tick_d        = tick_q + 1'b1;
    heartbeat_d   = tick_q[HB_MSB] & tick_q[HB_MSB-2];
    lockup_seen_d = lockup_seen_q | bus.LOCKUP;
    lock_cnt_d    = lock_cnt_q;
    if (bus.LOCKUP && !lock_prev_q && (lock_cnt_q != 8'hFF)) begin
      lock_cnt_d = lock_cnt_q + 8'd1;
    end
    mode_d = mode_q;
    if (kp_ext_w[1]) begin
      mode_d = MODE_STATUS;
    end else if (kp_ext_w[0]) begin
      mode_d = (mode_q == MODE_LOCKCNT) ? MODE_STATUS : mode_q + 2'd1;
    end
  end

  always_comb begin
    hex_d = {(7*NUM_DIGITS){1'b1}};
    case (mode_q)
      MODE_STATUS: begin
        hex_d[6:0]   = heartbeat_q   ? 7'b0100011 : BLANK;
        hex_d[13:7]  = bus.LOCKUP    ? BLANK      : 7'b1111110;
        hex_d[20:14] = running_q     ? 7'b1010111 : BLANK;
        hex_d[27:21] = lockup_seen_q ? 7'b1000111 : BLANK;
      end
      MODE_HEX: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          hex_d[7*i +: 7] = seg7(bus.value[4*i +: 4]);
        end
      end
      MODE_LOCKCNT: begin
        hex_d[6:0]  = seg7(lock_cnt_q[3:0]);
        hex_d[13:7] = seg7(lock_cnt_q[7:4]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) begin
      tick_q        <= '0;
      heartbeat_q   <= 1'b0;
      running_q     <= 1'b0;
      lockup_seen_q <= 1'b0;
      lock_prev_q   <= 1'b0;
      lock_cnt_q    <= 8'h00;
      mode_q        <= MODE_STATUS;
      hex_q         <= {(7*NUM_DIGITS){1'b1}};
    end else begin
      tick_q        <= tick_d;
      heartbeat_q   <= heartbeat_d;
      running_q     <= 1'b1;
      lockup_seen_q <= lockup_seen_d;
      lock_prev_q   <= bus.LOCKUP;
      lock_cnt_q    <= lock_cnt_d;
      mode_q        <= mode_d;
      hex_q         <= hex_d;
    end
  end

  assign bus.key_level   = key_level_w;
  assign bus.key_press   = key_press_w;
  assign bus.heartbeat   = heartbeat_q;
  assign bus.running     = running_q;
  assign bus.lockup_seen = lockup_seen_q;
  assign bus.mode        = mode_q;
  assign bus.hex_n       = hex_q;

endmodule
`default_nettype wire

// File: tb/tb_board_status_display.sv
`default_nettype none
// tb_board_status_display: directed, table-driven and randomised checks against a behavioural model.
module tb_board_status_display;
  localparam int ND = 4;
  localparam int NK = 2;
  localparam int HB = 4;
  localparam int DB = 4;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  board_status_display_if #(.NUM_DIGITS(ND), .NUM_KEYS(NK)) bus();

  board_status_display #(
    .NUM_DIGITS(ND), .HB_MSB(HB), .DEBOUNCE_CYCLES(DB), .NUM_KEYS(NK)
  ) dut (
    .CLOCK_50(clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- behavioural reference model ----------------
  logic [NK-1:0]   m_hist[$];   // raw pressed samples, newest first
  int              m_tick, m_cnt;
  logic            m_hb, m_run, m_seen, m_prev;
  logic [1:0]      m_mode;
  logic [NK-1:0]   m_lvl, m_press;
  logic [7*ND-1:0] m_hex;

  function automatic logic [7*ND-1:0] disp(input logic [1:0] md, input logic hb, input logic lk,
                                           input logic run, input logic seen,
                                           input logic [4*ND-1:0] val, input int cnt);
    logic [7*ND-1:0] h;
    h = '1;
    if (md == 2'd0) begin
      h[6:0]   = hb   ? 7'b0100011 : BL;
      h[13:7]  = lk   ? BL : 7'b1111110;
      h[20:14] = run  ? 7'b1010111 : BL;
      h[27:21] = seen ? 7'b1000111 : BL;
    end else if (md == 2'd1) begin
      for (int i = 0; i < ND; i++) h[7*i +: 7] = SEG[val[4*i +: 4]];
    end else if (md == 2'd2) begin
      h[6:0]  = SEG[cnt % 16];
      h[13:7] = SEG[cnt / 16];
    end
    return h;
  endfunction

  task automatic m_reset();
    m_hist.delete();
    for (int i = 0; i < DB + 2; i++) m_hist.push_back('0);
    m_tick = 0; m_cnt = 0; m_hb = 0; m_run = 0; m_seen = 0; m_prev = 0;
    m_mode = 0; m_lvl = '0; m_press = '0; m_hex = '1;
  endtask

  task automatic m_step();
    logic [7*ND-1:0] nhex;
    logic [1:0]      nmode;
    logic [NK-1:0]   nlvl, npress;
    logic            stable;
    nhex = disp(m_mode, m_hb, bus.LOCKUP, m_run, m_seen, bus.value, m_cnt);
    if (m_press[1])      nmode = 2'd0;
    else if (m_press[0]) nmode = 2'((int'(m_mode) + 1) % 3);
    else                 nmode = m_mode;
    m_hist.push_front(~bus.KEY_n);
    void'(m_hist.pop_back());
    // a key changes once its synchronised value has disagreed for DB samples in a row
    for (int k = 0; k < NK; k++) begin
      stable = 1'b1;
      for (int j = 2; j < DB + 2; j++) if (m_hist[j][k] == m_lvl[k]) stable = 1'b0;
      nlvl[k]   = stable ? ~m_lvl[k] : m_lvl[k];
      npress[k] = stable & ~m_lvl[k];
    end
    m_hb   = ((m_tick >> HB) & 1) == 1 && ((m_tick >> (HB - 2)) & 1) == 1;
    m_tick = (m_tick + 1) % (1 << (HB + 1));
    m_run  = 1'b1;
    if (bus.LOCKUP) m_seen = 1'b1;
    if (bus.LOCKUP && !m_prev && m_cnt < 255) m_cnt++;
    m_prev  = bus.LOCKUP;
    m_mode  = nmode;
    m_lvl   = nlvl;
    m_press = npress;
    m_hex   = nhex;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {27'b0, bus.key_level, bus.key_press, bus.heartbeat, bus.running,
            bus.lockup_seen, bus.mode, bus.hex_n};
  endfunction

  function automatic logic [63:0] mdl_vec();
    return {27'b0, m_lvl, m_press, m_hb, m_run, m_seen, m_mode, m_hex};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("model", dut_vec(), mdl_vec());
    end
  endtask

  task automatic press(input logic [NK-1:0] keys);
    bus.KEY_n = ~keys;
    step(DB + 4);
    bus.KEY_n = '1;
    step(DB + 4);
  endtask

  typedef struct {
    logic [4*ND-1:0] val;
    logic [7*ND-1:0] hex;
  } vec_t;
  vec_t tbl[5];

  int   presses;
  logic saw;
  int   hold;

  initial begin
    tbl[0] = '{16'hA5F0, {7'b0001000, 7'b0010010, 7'b0001110, 7'b1000000}};
    tbl[1] = '{16'h0001, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001}};
    tbl[2] = '{16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    tbl[3] = '{16'h6789, {7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000}};
    tbl[4] = '{16'hBCDE, {7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110}};

    rst_n      = 1'b0;
    bus.KEY_n  = '1;
    bus.LOCKUP = 1'b0;
    bus.value  = '0;

    // reset and heartbeat timing
    step(3);
    chk("reset_hex", bus.hex_n, {(7*ND){1'b1}});
    chk("reset_running", bus.running, 1'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      step(1);
      if (e == 1)  chk("running_after_release", bus.running, 1'b1);
      if (e == 20) chk("hb_before_20", bus.heartbeat, 1'b0);
      if (e == 21) chk("hb_at_20", bus.heartbeat, 1'b1);
      if (e == 21) chk("digit0_blank", bus.hex_n[6:0], BL);
      if (e == 22) chk("digit0_hb", bus.hex_n[6:0], 7'b0100011);
    end

    // 3-cycle glitch is filtered
    bus.KEY_n[0] = 1'b0;
    step(3);
    bus.KEY_n[0] = 1'b1;
    saw = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step(1);
      saw |= bus.key_level[0] | bus.key_press[0];
    end
    chk("glitch_filtered", saw, 1'b0);

    // clean press: level at edge 6, single pulse
    bus.KEY_n[0] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step(1);
      if (e == 5) chk("lvl_edge5", bus.key_level[0], 1'b0);
      if (e == 6) chk("lvl_edge6", bus.key_level[0], 1'b1);
      if (e == 6) chk("press_edge6", bus.key_press[0], 1'b1);
      if (e == 7) chk("press_edge7", bus.key_press[0], 1'b0);
    end
    bus.KEY_n[0] = 1'b1;
    step(DB + 4);
    chk("mode_after_press", bus.mode, 2'd1);

    // mode cycling
    press(2'b10); chk("mode_clear", bus.mode, 2'd0);
    press(2'b01); chk("mode_1", bus.mode, 2'd1);
    press(2'b01); chk("mode_2", bus.mode, 2'd2);
    press(2'b01); chk("mode_wrap", bus.mode, 2'd0);
    press(2'b01);
    press(2'b11); chk("mode_both_keys", bus.mode, 2'd0);

    // HEX mode table
    press(2'b01);
    foreach (tbl[i]) begin
      bus.value = tbl[i].val;
      step(1);
      chk("hex_table", bus.hex_n, tbl[i].hex);
    end

    // lockup counter saturation
    press(2'b01);
    for (int i = 0; i < 300; i++) begin
      bus.LOCKUP = 1'b1; step(1);
      bus.LOCKUP = 1'b0; step(1);
    end
    step(1);
    chk("lockcnt_ff", bus.hex_n[13:0], {SEG[15], SEG[15]});
    chk("lockcnt_hi_blank", bus.hex_n[27:14], {BL, BL});
    chk("lockup_seen", bus.lockup_seen, 1'b1);
    press(2'b10);
    chk("status_d1_idle", bus.hex_n[13:7], 7'b1111110);
    chk("status_d3_sticky", bus.hex_n[27:21], 7'b1000111);
    bus.LOCKUP = 1'b1; step(1);
    chk("status_d1_lockup", bus.hex_n[13:7], BL);
    bus.LOCKUP = 1'b0; step(1);
    chk("status_d1_back", bus.hex_n[13:7], 7'b1111110);
    chk("status_d3_after", bus.hex_n[27:21], 7'b1000111);
    rst_n = 1'b0; #1;
    chk("seen_cleared", bus.lockup_seen, 1'b0);
    step(2);
    rst_n = 1'b1;
    press(2'b01);
    press(2'b01);
    chk("lockcnt_cleared", bus.hex_n[13:0], {SEG[0], SEG[0]});

    // reset while a key is held
    bus.KEY_n[1] = 1'b0;
    step(DB + 4);
    chk("held_level", bus.key_level[1], 1'b1);
    rst_n = 1'b0; #1;
    chk("held_level_in_reset", bus.key_level[1], 1'b0);
    step(2);
    rst_n = 1'b1;
    presses = 0;
    for (int e = 1; e <= 12; e++) begin
      step(1);
      if (bus.key_press[1]) presses++;
      if (e == 5) chk("rehold_edge5", bus.key_level[1], 1'b0);
      if (e == 6) chk("rehold_edge6", bus.key_level[1], 1'b1);
    end
    chk("rehold_presses", presses, 1);
    bus.KEY_n[1] = 1'b1;
    step(DB + 4);

    // randomised traffic against the model
    hold = 0;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        bus.KEY_n = NK'($urandom);
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 3) == 0) bus.LOCKUP = ~bus.LOCKUP;
      if ($urandom_range(0, 7) == 0) bus.value = (4*ND)'($urandom);
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
